// File: rtl/spectrum_bin_collector.sv
// spectrum_bin_collector
// Sink for the FFT output stream. Folds each 2**IDX_W-bin frame into NUM_COLS
// display columns by keeping the peak magnitude per column. Only a complete,
// in-order frame is published into the display bank that the matrix driver
// reads by column address.
// Optional build macro SPECTRUM_DECAY_EN: on publish each displayed peak falls
// by at most DECAY_STEP per frame instead of jumping straight down.
module spectrum_bin_collector #(
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 8,
    parameter int NUM_COLS   = 16,
    parameter int COL_SHIFT  = 3,
    parameter int DECAY_STEP = 512,
    localparam int COL_AW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int MAG_W     = DATA_W - 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] data_out,
    input  logic                     data_out_valid,
    input  logic [IDX_W-1:0]         output_index,
    output logic                     slave_ready,
    input  logic [COL_AW-1:0]        col_addr,
    output logic [MAG_W-1:0]         col_level,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [15:0]              frame_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    // |v| saturated to MAG_W bits; the most negative input maps to full scale.
    function automatic logic [MAG_W-1:0] sat_mag(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] a;
        a = v[DATA_W-1] ? -v : v;
        if (a[DATA_W-1]) begin
            return '1;
        end
        return a[MAG_W-1:0];
    endfunction

    // Displayed peak falls by DECAY_STEP (floored at 0) unless the new peak is higher.
    function automatic logic [MAG_W-1:0] decay_peak(input logic [MAG_W-1:0] w,
                                                    input logic [MAG_W-1:0] d);
        logic [MAG_W-1:0] step;
        logic [MAG_W-1:0] fell;
        step = MAG_W'(DECAY_STEP);
        fell = (d > step) ? (d - step) : '0;
        return (w > fell) ? w : fell;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic [MAG_W-1:0] work_q [NUM_COLS];
    logic [MAG_W-1:0] work_d [NUM_COLS];
    logic [MAG_W-1:0] disp_q [NUM_COLS];
    logic [MAG_W-1:0] disp_d [NUM_COLS];
    logic [15:0]      count_q, count_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic [MAG_W-1:0] level_q;

    logic             xfer;
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] col_full;
    logic [COL_AW-1:0] col_sel;
    logic             col_ok;

    assign xfer     = data_out_valid && ready_q;
    assign mag      = sat_mag(data_out);
    assign col_full = output_index >> COL_SHIFT;
    assign col_sel  = col_full[COL_AW-1:0];
    assign col_ok   = (int'(col_full) < NUM_COLS);

    // Frame tracking: fold in-order bins, abort on a gap in the index, publish at the last bin.
    always_comb begin
        state_d   = state_q;
        exp_idx_d = exp_idx_q;
        count_d   = count_q;
        err_d     = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            work_d[c] = work_q[c];
            disp_d[c] = disp_q[c];
        end

        case (state_q)
            S_IDLE: begin
                // work[] is already clear here, so only column 0 needs loading.
                if (xfer && output_index == '0) begin
                    work_d[0] = mag;
                    exp_idx_d = IDX_W'(1);
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    if (output_index == exp_idx_q) begin
                        if (col_ok && mag > work_q[col_sel]) begin
                            work_d[col_sel] = mag;
                        end
                        exp_idx_d = exp_idx_q + IDX_W'(1);
                        if (output_index == LAST_IDX) begin
                            state_d = S_PUBLISH;
                        end
                    end else begin
                        // Broken frame: drop it; an index-0 bin restarts collection at once.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        for (int c = 0; c < NUM_COLS; c++) begin
                            work_d[c] = '0;
                        end
                        if (output_index == '0) begin
                            work_d[0] = mag;
                            exp_idx_d = IDX_W'(1);
                            state_d   = S_COLLECT;
                        end
                    end
                end
            end
            S_PUBLISH: begin
                for (int c = 0; c < NUM_COLS; c++) begin
`ifdef SPECTRUM_DECAY_EN
                    disp_d[c] = decay_peak(work_q[c], disp_q[c]);
`else
                    disp_d[c] = work_q[c];
`endif
                    work_d[c] = '0;
                end
                count_d = count_q + 16'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready is registered; it drops exactly for the publish cycle.
        ready_d = (state_d != S_PUBLISH);
    end

    // State, working/display banks and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            exp_idx_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                work_q[c] <= '0;
                disp_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            exp_idx_q <= exp_idx_d;
            count_q   <= count_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            for (int c = 0; c < NUM_COLS; c++) begin
                work_q[c] <= work_d[c];
                disp_q[c] <= disp_d[c];
            end
        end
    end

    // Registered read port; a read during publish still sees the old bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else if (int'(col_addr) < NUM_COLS) begin
            level_q <= disp_q[col_addr];
        end else begin
            level_q <= '0;
        end
    end

    assign slave_ready = ready_q;
    assign col_level   = level_q;
    assign frame_done  = (state_q == S_PUBLISH);
    assign frame_err   = err_q;
    assign frame_count = count_q;

endmodule

// File: doc/spectrum_bin_collector.md
Name: spectrum_bin_collector

Overview:
- Sink for the FFT wrapper's output stream: drives slave_ready and consumes data_out, data_out_valid and output_index.
- Folds the bins of each FFT frame into NUM_COLS display columns, keeping the peak magnitude of each column.
- Publishes one complete frame at a time into a display register bank, which the rainbow matrix driver reads by column address.

Parameters:
- DATA_W, 16, width of FFT output word (signed two's complement).
- IDX_W, 8, width of output_index; frame length is 2**IDX_W bins.
- NUM_COLS, 16, number of display columns (partial spectrum).
- COL_SHIFT, 3, log2 bins per column; column = output_index >> COL_SHIFT.
- DECAY_STEP, 512, per-frame fall amount used only with SPECTRUM_DECAY_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_out  in  DATA_W  FFT bin value, signed.
- data_out_valid  in  1  bin value valid.
- output_index  in  IDX_W  bin index of data_out.
- slave_ready  out  1  collector can accept a bin.
- col_addr  in  clog2(NUM_COLS)  display read address.
- col_level  out  DATA_W-1  published peak magnitude of col_addr, registered.
- frame_done  out  1  one-cycle pulse when a new frame is published.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- frame_count  out  16  number of frames published, wraps.

Behaviour:
- Reset is asynchronous. Values during and after reset:
  - slave_ready=0, col_level=0, frame_done=0, frame_err=0, frame_count=0.
  - All working and display registers = 0. State = IDLE.
- Transfer occurs on any cycle with data_out_valid && slave_ready. Nothing else changes state.
- Magnitude: mag = |data_out| saturated to DATA_W-1 bits, so -32768 maps to 32767.
- Bins with column >= NUM_COLS are accepted but ignored; they still advance the expected index.
- States:
  - IDLE:
    - slave_ready=1.
    - A transfer with index 0 loads work[0] = mag (all other work[] already 0) and sets expect=1; go to COLLECT.
    - Transfers with any other index are dropped silently.
  - COLLECT:
    - slave_ready=1.
    - A transfer with index == expect updates work[col] = max(work[col], mag) and increments expect.
    - At index == 2**IDX_W-1, go to PUBLISH.
    - A transfer with index != expect is an error: pulse frame_err, clear work[], go to IDLE.
    - Special case: if the mismatched index is 0, it is also taken as the start of a new frame, with the same actions as IDLE.
  - PUBLISH (exactly 1 cycle):
    - slave_ready=0.
    - disp[c] <= work[c] for all c; work[] cleared.
    - frame_done pulses in this cycle; frame_count increments.
    - Next state IDLE.
- Latency: frame_done is asserted on the cycle after the transfer of the last bin.
- Read port:
  - col_level is registered with 1-cycle latency from col_addr.
  - col_addr >= NUM_COLS returns 0.
  - A read in the same cycle as PUBLISH returns the old disp value; the new value is visible on the next cycle.
- Idle gaps (data_out_valid=0) are allowed anywhere with no timeout; the frame stays open.
- Equal magnitudes leave work[] unchanged.
- frame_count wraps from 0xFFFF to 0.

Optional Feature:
- Macro: SPECTRUM_DECAY_EN.
- Defined: PUBLISH writes disp[c] <= max(work[c], disp[c] - DECAY_STEP). The subtraction saturates at 0. Peaks fall gradually instead of jumping down.
- Undefined: disp[c] <= work[c] directly, as specified above.

Test Plan:
- Reset, then one full frame of 256 bins:
  - Stimulus: data_out = 100 on every bin, except bin 9 = -2000 and bin 127 = 32767.
  - Required: frame_done pulses 1 cycle after bin 255. frame_count = 1. col 1 reads 2000, col 15 reads 32767, all other columns read 100.
- Saturation: bin 0 = -32768 in an otherwise zero frame -> col 0 reads 32767.
- Out-of-order bins:
  - Stimulus: bins 0..4, then bin 7.
  - Required: frame_err pulses, no frame_done, frame_count unchanged, display holds previous values.
  - Follow-up: a full in-order frame then publishes normally.
- Backpressure and gaps:
  - Stimulus: data_out_valid held high across the publish cycle; data_out_valid toggled every other cycle during a frame.
  - Required: slave_ready is 0 only in the PUBLISH cycle. The bin presented then is not consumed. Results equal the gap-free run.
- Reset mid-frame:
  - Stimulus: reset_n pulsed low after bin 50.
  - Required: all outputs return to 0 immediately, and the next frame starting at index 0 publishes correctly.
- With SPECTRUM_DECAY_EN:
  - Stimulus: frame 1 col 2 = 4000, frame 2 col 2 = 0.
  - Required: col 2 reads 4000 after frame 1, then 3488 after frame 2.
